// File: rtl/weight_row_mac_if.sv
// rtl/weight_row_mac_if.sv - row input and result handshake bundle for weight_row_mac
//
// Signals:
//   in_valid, w0..w2, x0..x2 : one weight/activation row offered to the MAC
//   out_valid, out_ready     : result handshake toward the activation stage
//   acc_out, sat             : accumulated result and its saturation flag
// Modports:
//   slave  : the MAC (consumes rows, produces results)
//   master : the surrounding logic (produces rows, consumes results)
interface weight_row_mac_if #(
    parameter int W_WIDTH   = 4,
    parameter int X_WIDTH   = 4,
    parameter int ACC_WIDTH = 16
);
    logic                 in_valid;
    logic [W_WIDTH-1:0]   w0, w1, w2;
    logic [X_WIDTH-1:0]   x0, x1, x2;
    logic                 out_ready;
    logic                 out_valid;
    logic [ACC_WIDTH-1:0] acc_out;
    logic                 sat;

    modport slave (
        input  in_valid, w0, w1, w2, x0, x1, x2, out_ready,
        output out_valid, acc_out, sat
    );

    modport master (
        output in_valid, w0, w1, w2, x0, x1, x2, out_ready,
        input  out_valid, acc_out, sat
    );
endinterface

// File: rtl/weight_row_mac.sv
// rtl/weight_row_mac.sv - three-wide row dot product accumulated over ROWS rows with saturation
//
// Ports:
//   clk      : clock, all logic on the rising edge
//   rst      : synchronous active-high reset, overrides everything
//   start    : begin a new accumulation (IDLE, or HOLD together with out_ready)
//   busy     : high whenever the block is not IDLE
//   row_idx  : rows accepted in the current accumulation
//   bus      : row input (in_valid, w0..w2, x0..x2) and result handshake
//              (out_valid, out_ready, acc_out, sat)
module weight_row_mac #(
    parameter int W_WIDTH   = 4,
    parameter int X_WIDTH   = 4,
    parameter int ROWS      = 3,
    parameter int ACC_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic [7:0]              row_idx,
    weight_row_mac_if.slave         bus
);
    localparam int RS_W  = W_WIDTH + X_WIDTH + 2;
    // The sum must hold both operands plus a carry, whichever is wider.
    localparam int SUM_W = ((ACC_WIDTH > RS_W) ? ACC_WIDTH : RS_W) + 1;
    localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [7:0]           row_q, row_d;
    logic                 sat_q, sat_d;
    logic                 ov_q, ov_d;

    logic [RS_W-1:0]      row_sum;
    logic [SUM_W-1:0]     sum;
    logic                 overflow;

    assign row_sum = RS_W'(bus.w0) * RS_W'(bus.x0)
                   + RS_W'(bus.w1) * RS_W'(bus.x1)
                   + RS_W'(bus.w2) * RS_W'(bus.x2);
    assign sum      = SUM_W'(acc_q) + SUM_W'(row_sum);
    // Any bit above the accumulator width means the result no longer fits.
    assign overflow = |sum[SUM_W-1:ACC_WIDTH];

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        row_d   = row_q;
        sat_d   = sat_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    row_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            ACCUM: begin
                if (bus.in_valid) begin
                    acc_d = overflow ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
                    sat_d = sat_q | overflow;
                    row_d = row_q + 8'd1;
                    if (row_q == LAST_ROW) begin
                        state_d = HOLD;
                        ov_d    = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    ov_d = 1'b0;
                    if (start) begin
                        // Back-to-back: hand off the result and restart at once.
                        state_d = ACCUM;
                        acc_d   = '0;
                        row_d   = '0;
                        sat_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            row_q   <= '0;
            sat_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            row_q   <= row_d;
            sat_q   <= sat_d;
            ov_q    <= ov_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign row_idx       = row_q;
    assign bus.acc_out   = acc_q;
    assign bus.sat       = sat_q;
    assign bus.out_valid = ov_q;
endmodule
